uart_cmd_decoder: RTL and testbench



---
 rtl/uart_cmd_decoder.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Two-byte command frame decoder (address, code) between the UART receiver and
// the sensor controller; rejects bad frames with an error pulse and counts overruns.
module uart_cmd_decoder #(
  parameter int unsigned BYTE_TIMEOUT = 3480,
  parameter int unsigned NUM_SENSORS  = 32,
  parameter logic [7:0]  MAX_CMD      = 8'h06
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Cmd_Valid,
  input  logic       i_Cmd_Ready,
  output logic [7:0] o_Cmd_Addr,
  output logic [7:0] o_Cmd_Code,
  output logic       o_Err_Valid,
  output logic [1:0] o_Err_Code,
  output logic [7:0] o_Drop_Count
);

  localparam int unsigned TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BYTE_TIMEOUT - 1);

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_BAD_ADDR = 2'b10;
  localparam logic [1:0] ERR_BAD_CMD  = 2'b11;

  typedef enum logic [1:0] {
    S_WAIT_ADDR,
    S_WAIT_CMD,
    S_CHECK,
    S_OUTPUT
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    code_q, code_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [7:0]    cmd_addr_q, cmd_addr_d;
  logic [7:0]    cmd_code_q, cmd_code_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          err_pend_q, err_pend_d;
  logic [1:0]    err_pend_code_q, err_pend_code_d;
  logic [7:0]    drop_q, drop_d;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    code_d          = code_q;
    tmo_d           = tmo_q;
    cmd_valid_d     = cmd_valid_q;
    cmd_addr_d      = cmd_addr_q;
    cmd_code_d      = cmd_code_q;
    err_valid_d     = 1'b0;
    err_code_d      = err_code_q;
    err_pend_d      = 1'b0;
    err_pend_code_d = err_pend_code_q;
    drop_d          = drop_q;

    // Check-stage verdicts pass through one register so both outcomes land
    // two clocks after the command byte.
    if (err_pend_q) begin
      err_valid_d = 1'b1;
      err_code_d  = err_pend_code_q;
    end

    unique case (state_q)
      S_WAIT_ADDR: begin
        if (i_Rx_DV) begin
          addr_d  = i_Rx_Byte;
          tmo_d   = '0;
          state_d = S_WAIT_CMD;
        end
      end
      S_WAIT_CMD: begin
        if (i_Rx_DV) begin
          code_d  = i_Rx_Byte;
          state_d = S_CHECK;
        end else if (tmo_q == TMO_LAST) begin
          err_valid_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          addr_d      = '0;
          state_d     = S_WAIT_ADDR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (32'(addr_q) >= NUM_SENSORS) begin
          err_pend_d      = 1'b1;
          err_pend_code_d = ERR_BAD_ADDR;
          state_d         = S_WAIT_ADDR;
        end else if (code_q > MAX_CMD) begin
          err_pend_d      = 1'b1;
          err_pend_code_d = ERR_BAD_CMD;
          state_d         = S_WAIT_ADDR;
        end else begin
          state_d = S_OUTPUT;
        end
      end
      S_OUTPUT: begin
        if (i_Rx_DV && (drop_q != '1)) begin
          drop_d = drop_q + 1'b1;
        end
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_addr_d  = addr_q;
          cmd_code_d  = code_q;
        end else if (i_Cmd_Ready) begin
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_ADDR;
        end
      end
      default: state_d = S_WAIT_ADDR;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q         <= S_WAIT_ADDR;
      addr_q          <= '0;
      code_q          <= '0;
      tmo_q           <= '0;
      cmd_valid_q     <= 1'b0;
      cmd_addr_q      <= '0;
      cmd_code_q      <= '0;
      err_valid_q     <= 1'b0;
      err_code_q      <= '0;
      err_pend_q      <= 1'b0;
      err_pend_code_q <= '0;
      drop_q          <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      code_q          <= code_d;
      tmo_q           <= tmo_d;
      cmd_valid_q     <= cmd_valid_d;
      cmd_addr_q      <= cmd_addr_d;
      cmd_code_q      <= cmd_code_d;
      err_valid_q     <= err_valid_d;
      err_code_q      <= err_code_d;
      err_pend_q      <= err_pend_d;
      err_pend_code_q <= err_pend_code_d;
      drop_q          <= drop_d;
    end
  end

  assign o_Cmd_Valid  = cmd_valid_q;
  assign o_Cmd_Addr   = cmd_addr_q;
  assign o_Cmd_Code   = cmd_code_q;
  assign o_Err_Valid  = err_valid_q;
  assign o_Err_Code   = err_code_q;
  assign o_Drop_Count = drop_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: legal/illegal frames, timeout boundary,
// backpressure with drop saturation, and reset in mid-frame.
module tb_uart_cmd_decoder;

  localparam int unsigned TMO = 3480;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_code;
  logic       err_valid;
  logic [1:0] err_code;
  logic [7:0] drop_count;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int err_seen = 0;

  uart_cmd_decoder #(
    .BYTE_TIMEOUT(TMO),
    .NUM_SENSORS (32),
    .MAX_CMD     (8'h06)
  ) dut (
    .i_Clock     (clk),
    .i_Rst_n     (rst_n),
    .i_Rx_DV     (rx_dv),
    .i_Rx_Byte   (rx_byte),
    .o_Cmd_Valid (cmd_valid),
    .i_Cmd_Ready (cmd_ready),
    .o_Cmd_Addr  (cmd_addr),
    .o_Cmd_Code  (cmd_code),
    .o_Err_Valid (err_valid),
    .o_Err_Code  (err_code),
    .o_Drop_Count(drop_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1 && err_valid === 1'b1) err_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    tick();
    rx_dv   = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_addr"},  32'(cmd_addr),  32'd0);
    chk({tag, "_code"},  32'(cmd_code),  32'd0);
    chk({tag, "_err"},   32'(err_valid), 32'd0);
    chk({tag, "_ecode"}, 32'(err_code),  32'd0);
    chk({tag, "_drop"},  32'(drop_count), 32'd0);
  endtask

  task automatic bad_frame(input string tag, input logic [7:0] a, input logic [7:0] c,
                           input logic [1:0] exp_code);
    send_byte(a);
    send_byte(c);
    tick();
    chk({tag, "_err_e1"}, 32'(err_valid), 32'd0);
    tick();
    chk({tag, "_err_e2"}, 32'(err_valid), 32'd1);
    chk({tag, "_code"},   32'(err_code),  32'(exp_code));
    chk({tag, "_novalid"}, 32'(cmd_valid), 32'd0);
    tick();
    chk({tag, "_err_e3"}, 32'(err_valid), 32'd0);
    chk({tag, "_novalid3"}, 32'(cmd_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    cmd_ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst_n = 1'b1;

    // Legal frame
    cmd_ready = 1'b1;
    send_byte(8'h05);
    send_byte(8'h01);
    chk("legal_e0", 32'(cmd_valid), 32'd0);
    tick();
    chk("legal_e1", 32'(cmd_valid), 32'd0);
    tick();
    chk("legal_valid", 32'(cmd_valid), 32'd1);
    chk("legal_addr",  32'(cmd_addr),  32'h05);
    chk("legal_code",  32'(cmd_code),  32'h01);
    tick();
    chk("legal_oneshot", 32'(cmd_valid), 32'd0);
    chk("legal_drop",    32'(drop_count), 32'd0);
    chk("legal_noerr",   32'(err_seen),  32'd0);

    // Bad fields
    bad_frame("badaddr", 8'h20, 8'h01, 2'b10);
    bad_frame("badcmd",  8'h03, 8'h07, 2'b11);
    bad_frame("badboth", 8'h40, 8'hFF, 2'b10);
    chk("bad_errcount", 32'(err_seen), 32'd3);

    // Timeout boundary
    send_byte(8'h02);
    repeat (TMO - 1) tick();
    chk("tmo_early", 32'(err_valid), 32'd0);
    tick();
    chk("tmo_err",  32'(err_valid), 32'd1);
    chk("tmo_code", 32'(err_code),  32'd1);
    tick();
    chk("tmo_pulse", 32'(err_valid), 32'd0);
    chk("tmo_errcount", 32'(err_seen), 32'd4);

    // Command byte on the expiry edge wins
    send_byte(8'h02);
    repeat (TMO - 1) tick();
    send_byte(8'h03);
    chk("tmo_win_noerr", 32'(err_valid), 32'd0);
    tick();
    tick();
    chk("tmo_win_valid", 32'(cmd_valid), 32'd1);
    chk("tmo_win_addr",  32'(cmd_addr),  32'h02);
    chk("tmo_win_code",  32'(cmd_code),  32'h03);
    tick();
    chk("tmo_win_done",  32'(cmd_valid), 32'd0);
    chk("tmo_win_errcount", 32'(err_seen), 32'd4);

    // Backpressure and overrun
    cmd_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    tick();
    tick();
    chk("bp_valid", 32'(cmd_valid), 32'd1);
    for (int i = 0; i < 254; i++) send_byte(8'(i));
    chk("bp_drop254", 32'(drop_count), 32'd254);
    for (int i = 0; i < 46; i++) send_byte(8'(i + 7));
    chk("bp_drop_sat", 32'(drop_count), 32'd255);
    chk("bp_hold_valid", 32'(cmd_valid), 32'd1);
    chk("bp_hold_addr",  32'(cmd_addr),  32'h01);
    chk("bp_hold_code",  32'(cmd_code),  32'h02);
    cmd_ready = 1'b1;
    tick();
    chk("bp_xfer", 32'(cmd_valid), 32'd0);
    send_byte(8'h04);
    send_byte(8'h00);
    tick();
    tick();
    chk("bp_next_valid", 32'(cmd_valid), 32'd1);
    chk("bp_next_addr",  32'(cmd_addr),  32'h04);
    chk("bp_next_code",  32'(cmd_code),  32'h00);
    tick();
    chk("bp_next_done", 32'(cmd_valid), 32'd0);
    chk("bp_drop_keep", 32'(drop_count), 32'd255);
    chk("bp_errcount",  32'(err_seen),  32'd4);

    // Reset after an address byte
    send_byte(8'h07);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("rst_addr");
    send_byte(8'h00);
    send_byte(8'h06);
    tick();
    tick();
    chk("rst_addr_valid", 32'(cmd_valid), 32'd1);
    chk("rst_addr_a",     32'(cmd_addr),  32'h00);
    chk("rst_addr_c",     32'(cmd_code),  32'h06);
    tick();

    // Reset while a command is pending
    cmd_ready = 1'b0;
    send_byte(8'h03);
    send_byte(8'h01);
    tick();
    tick();
    chk("rst_pend_valid", 32'(cmd_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    chk_idle("rst_pend");
    tick();
    chk("rst_pend_noerr", 32'(err_valid), 32'd0);
    send_byte(8'h00);
    send_byte(8'h06);
    tick();
    tick();
    chk("rst_pend_next_valid", 32'(cmd_valid), 32'd1);
    chk("rst_pend_next_addr",  32'(cmd_addr),  32'h00);
    chk("rst_pend_next_code",  32'(cmd_code),  32'h06);
    tick();
    chk("rst_pend_next_done",  32'(cmd_valid), 32'd0);
    chk("final_errcount", 32'(err_seen), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
